alu_mc_controller: RTL

//  Multicycle control FSM for the RV32I core datapath. Sequences fetch/decode/execute/memory/writeback.

---
 rtl/alu_mc_controller.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, drives datapath controls, counts retirements.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP and raise sticky o_illegal.
module alu_mc_controller #(
  parameter int INSTRET_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7_5,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_pc_write,
  output logic                 o_adr_src,
  output logic                 o_mem_write,
  output logic                 o_ir_write,
  output logic                 o_reg_write,
  output logic [1:0]           o_result_src,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_imm_src,
  output logic [2:0]           o_alu_control,
  output logic [INSTRET_W-1:0] o_instret,
  output logic                 o_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire;
  logic [2:0]           funct_op;

  // Only EXECR may turn funct3=000 into a subtract; immediates with bit 30 set stay add.
  always_comb begin
    funct_op = ALU_ADD;
    case (i_funct3)
      3'b000:  funct_op = (state_q == S_EXECR && i_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_op = ALU_SLT;
      3'b110:  funct_op = ALU_OR;
      3'b111:  funct_op = ALU_AND;
      default: funct_op = ALU_ADD;
    endcase
  end

  always_comb begin
    o_imm_src = 2'b00;
    case (i_opcode)
      OP_STORE:  o_imm_src = 2'b01;
      OP_BRANCH: o_imm_src = 2'b10;
      OP_JAL:    o_imm_src = 2'b11;
      default:   o_imm_src = 2'b00;
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_dec;
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_dec = 1'b0;
    case (i_opcode)
      OP_LOAD, OP_STORE, OP_JAL: illegal_dec = 1'b0;
      OP_R, OP_I: illegal_dec = !(i_funct3 == 3'b000 || i_funct3 == 3'b010 ||
                                  i_funct3 == 3'b110 || i_funct3 == 3'b111);
      OP_BRANCH: illegal_dec = (i_funct3 != 3'b000);
      default:   illegal_dec = 1'b1;
    endcase
  end
`endif

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    o_pc_write    = 1'b0;
    o_adr_src     = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_result_src  = 2'b00;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_alu_control = ALU_ADD;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        o_ir_write   = i_mem_ready;
        o_pc_write   = i_mem_ready;
        if (i_mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        case (i_opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        if (illegal_dec) state_d = S_TRAP;
`endif
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        state_d     = i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adr_src = 1'b1;
        if (i_mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = 2'b01;
        o_reg_write  = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_write = i_mem_ready;
        if (i_mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        o_alu_src_a   = 2'b10;
        o_alu_control = funct_op;
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        o_alu_src_a   = 2'b10;
        o_alu_src_b   = 2'b01;
        o_alu_control = funct_op;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        o_alu_src_a   = 2'b10;
        o_alu_control = ALU_SUB;
        o_pc_write    = i_zero;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_pc_write  = 1'b1;
        state_d     = S_ALUWB;
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_RST;
    endcase
  end

  assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
  assign o_instret = instret_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_RST;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign o_illegal = illegal_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end
`else
  assign o_illegal = 1'b0;
`endif

endmodule
